traffic_sensor_conditioner: RTL and testbench

//   Producer side of the traffic_control request interface. Turns raw per-approach detector

---
 rtl/traffic_pkg.sv | 42 ++++
 rtl/lane_occupancy.sv | 107 ++++++++++
 rtl/traffic_sensor_conditioner.sv | 114 +++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic_control request interface: lane index
//   constants, the light encoding used by traffic_control, default tuning
//   values for the sensor conditioner and a fixed-priority one-hot helper.
//   Lane bit map on every per-lane bus: bit0=N, bit1=S, bit2=E, bit3=W.
package traffic_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_N    = 0;
  localparam int LANE_S    = 1;
  localparam int LANE_E    = 2;
  localparam int LANE_W    = 3;

  // Light encoding shared with traffic_control
  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2,
    LIGHT_FLASH  = 2'd3
  } light_t;

  // Default tuning values for the sensor conditioner
  localparam int DEF_QW         = 4;
  localparam int DEF_JAM_TH     = 12;
  localparam int DEF_JAM_HYST   = 4;
  localparam int DEF_EMPTY_HOLD = 8;
  localparam int DEF_DEB_CYC    = 3;

  // One-hot of the lowest set bit, so N beats S beats E beats W
  function automatic logic [NUM_LANES-1:0] priorityOneHot(input logic [NUM_LANES-1:0] v);
    logic [NUM_LANES-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_occupancy.sv
// lane_occupancy
//   Per-lane vehicle bookkeeping: rising-edge detect on the arrival and
//   stop-line loops, saturating occupancy counter, jam flag with hysteresis,
//   empty flag after a hold time at zero, and a sticky sensor error.
// Ports
//   clk      in  1  rising-edge clock
//   rst      in  1  asynchronous active-low reset
//   i_arr    in  1  arrival loop level (synchronous to clk)
//   i_dep    in  1  stop-line loop level (synchronous to clk)
//   o_jam    out 1  registered jam flag
//   o_empty  out 1  registered empty flag
//   o_err    out 1  sticky error: departure at 0 or arrival at saturation
module lane_occupancy
  import traffic_pkg::*;
#(
  parameter int QW         = DEF_QW,
  parameter int JAM_TH     = DEF_JAM_TH,
  parameter int JAM_HYST   = DEF_JAM_HYST,
  parameter int EMPTY_HOLD = DEF_EMPTY_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arr,
  input  logic i_dep,
  output logic o_jam,
  output logic o_empty,
  output logic o_err
);

  localparam int HW = $clog2(EMPTY_HOLD + 1);
  localparam logic [QW-1:0] OCC_MAX  = '1;
  localparam logic [QW-1:0] JAM_SET  = QW'(JAM_TH);
  localparam logic [QW-1:0] JAM_CLR  = QW'(JAM_TH - JAM_HYST);
  localparam logic [HW-1:0] HOLD_MAX = HW'(EMPTY_HOLD);

  logic          r_arrPrev;
  logic          r_depPrev;
  logic          r_arrRise;
  logic          r_depRise;
  logic [QW-1:0] r_occ;
  logic [HW-1:0] r_hold;
  logic          r_jam;
  logic          r_empty;
  logic          r_err;

  logic [QW-1:0] w_occNext;
  logic [HW-1:0] w_holdNext;
  logic          w_errSet;

  // Edge register: a loop held high counts once, on the cycle after it rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_arrPrev <= 1'b0;
      r_depPrev <= 1'b0;
      r_arrRise <= 1'b0;
      r_depRise <= 1'b0;
    end else begin
      r_arrPrev <= i_arr;
      r_depPrev <= i_dep;
      r_arrRise <= i_arr & ~r_arrPrev;
      r_depRise <= i_dep & ~r_depPrev;
    end
  end

  // Next occupancy; simultaneous in/out cancels, out-of-range steps hold and flag
  always_comb begin
    w_occNext = r_occ;
    w_errSet  = 1'b0;
    if (r_arrRise && !r_depRise) begin
      if (r_occ == OCC_MAX) w_errSet  = 1'b1;
      else                  w_occNext = r_occ + 1'b1;
    end else if (r_depRise && !r_arrRise) begin
      if (r_occ == '0) w_errSet  = 1'b1;
      else             w_occNext = r_occ - 1'b1;
    end
  end

  // Hold timer runs while the lane stays at zero, any vehicle restarts it
  always_comb begin
    w_holdNext = r_hold;
    if (w_occNext != '0)          w_holdNext = '0;
    else if (r_hold != HOLD_MAX)  w_holdNext = r_hold + 1'b1;
  end

  // Flags follow the next occupancy so they land with the counter update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ   <= '0;
      r_hold  <= '0;
      r_jam   <= 1'b0;
      r_empty <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_occ   <= w_occNext;
      r_hold  <= w_holdNext;
      r_empty <= (w_holdNext == HOLD_MAX);
      r_err   <= r_err | w_errSet;
      if (w_occNext >= JAM_SET)     r_jam <= 1'b1;
      else if (w_occNext < JAM_CLR) r_jam <= 1'b0;
    end
  end

  assign o_jam   = r_jam;
  assign o_empty = r_empty;
  assign o_err   = r_err;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
//   Producer side of the traffic_control request interface. Conditions raw
//   detector signals into registered emergency/jam/empty/sensor_err vectors.
//   Configuration macro: SENSOR_SYNC_EN adds a 2-flop synchronizer on every
//   veh_arr/veh_dep/siren bit (all latencies grow by 2 clk). Without it the
//   inputs are assumed synchronous to clk.
// Ports
//   clk         in  1  rising-edge clock
//   rst         in  1  asynchronous active-low reset
//   veh_arr     in  4  arrival loops, rising edge = one vehicle in
//   veh_dep     in  4  stop-line loops, rising edge = one vehicle out
//   siren       in  4  emergency detector levels
//   emergency   out 4  one-hot (or 0) validated emergency request
//   jam         out 4  per-lane jam flag
//   empty       out 4  per-lane empty flag
//   sensor_err  out 4  sticky per-lane sensor error
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int QW         = DEF_QW,
  parameter int JAM_TH     = DEF_JAM_TH,
  parameter int JAM_HYST   = DEF_JAM_HYST,
  parameter int EMPTY_HOLD = DEF_EMPTY_HOLD,
  parameter int DEB_CYC    = DEF_DEB_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] veh_arr,
  input  logic [NUM_LANES-1:0] veh_dep,
  input  logic [NUM_LANES-1:0] siren,
  output logic [NUM_LANES-1:0] emergency,
  output logic [NUM_LANES-1:0] jam,
  output logic [NUM_LANES-1:0] empty,
  output logic [NUM_LANES-1:0] sensor_err
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYC);

  logic [NUM_LANES-1:0] w_arr;
  logic [NUM_LANES-1:0] w_dep;
  logic [NUM_LANES-1:0] w_siren;
  logic [NUM_LANES-1:0] w_valid;
  logic [CW-1:0]        r_sirenCnt [NUM_LANES];
  logic [NUM_LANES-1:0] r_emergency;

`ifdef SENSOR_SYNC_EN
  logic [3*NUM_LANES-1:0] r_sync1;
  logic [3*NUM_LANES-1:0] r_sync2;

  // Two-flop synchronizer for detectors that live in another clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {siren, veh_dep, veh_arr};
      r_sync2 <= r_sync1;
    end
  end

  assign w_arr   = r_sync2[NUM_LANES-1:0];
  assign w_dep   = r_sync2[2*NUM_LANES-1:NUM_LANES];
  assign w_siren = r_sync2[3*NUM_LANES-1:2*NUM_LANES];
`else
  assign w_arr   = veh_arr;
  assign w_dep   = veh_dep;
  assign w_siren = siren;
`endif

  // One occupancy tracker per approach
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_occupancy #(
      .QW         (QW),
      .JAM_TH     (JAM_TH),
      .JAM_HYST   (JAM_HYST),
      .EMPTY_HOLD (EMPTY_HOLD)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_arr   (w_arr[g]),
      .i_dep   (w_dep[g]),
      .o_jam   (jam[g]),
      .o_empty (empty[g]),
      .o_err   (sensor_err[g])
    );
  end

  // Siren debounce: count consecutive high cycles, any low sample restarts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LANES; i++) r_sirenCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!w_siren[i])                   r_sirenCnt[i] <= '0;
        else if (r_sirenCnt[i] != DEB_MAX) r_sirenCnt[i] <= r_sirenCnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NUM_LANES; i++) w_valid[i] = (r_sirenCnt[i] == DEB_MAX);
  end

  // Registered fixed-priority grant; a lower lane takes over as soon as the winner drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_emergency <= '0;
    else      r_emergency <= priorityOneHot(w_valid);
  end

  assign emergency = r_emergency;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
module tb_traffic_sensor_conditioner;

`ifdef SENSOR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int DEB = 3;
  localparam int OCC_MAX = 15;
  localparam int JAM_ON = 12;
  localparam int JAM_OFF = 8;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] veh_arr;
  logic [3:0] veh_dep;
  logic [3:0] siren;
  logic [3:0] emergency;
  logic [3:0] jam;
  logic [3:0] empty;
  logic [3:0] sensor_err;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  traffic_sensor_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .veh_arr    (veh_arr),
    .veh_dep    (veh_dep),
    .siren      (siren),
    .emergency  (emergency),
    .jam        (jam),
    .empty      (empty),
    .sensor_err (sensor_err)
  );

  // Reference model: vehicle counts as integers, siren high-time as integers
  logic [11:0] mS1, mS2, mEff;
  logic [3:0]  mPrevA, mPrevD, mPendA, mPendD;
  logic [3:0]  mJam, mEmpty, mErr, mEm;
  int          mOcc [4];
  int          mHold [4];
  int          mSir [4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mS1 = '0; mS2 = '0;
      mPrevA = '0; mPrevD = '0; mPendA = '0; mPendD = '0;
      mJam = '0; mEmpty = '0; mErr = '0; mEm = '0;
      for (int i = 0; i < 4; i++) begin
        mOcc[i] = 0; mHold[i] = 0; mSir[i] = 0;
      end
    end else begin
`ifdef SENSOR_SYNC_EN
      mEff = mS2;
      mS2 = mS1;
      mS1 = {siren, veh_dep, veh_arr};
`else
      mEff = {siren, veh_dep, veh_arr};
`endif
      for (int i = 0; i < 4; i++) begin
        if (mPendA[i] && !mPendD[i]) begin
          if (mOcc[i] == OCC_MAX) mErr[i] = 1'b1; else mOcc[i]++;
        end else if (mPendD[i] && !mPendA[i]) begin
          if (mOcc[i] == 0) mErr[i] = 1'b1; else mOcc[i]--;
        end
        if (mOcc[i] >= JAM_ON) mJam[i] = 1'b1;
        else if (mOcc[i] < JAM_OFF) mJam[i] = 1'b0;
        if (mOcc[i] == 0) mHold[i] = (mHold[i] < HOLD) ? mHold[i] + 1 : HOLD;
        else mHold[i] = 0;
        mEmpty[i] = (mHold[i] == HOLD);
      end
      mEm = '0;
      for (int i = 3; i >= 0; i--) if (mSir[i] == DEB) mEm = 4'(1 << i);
      for (int i = 0; i < 4; i++) begin
        if (mEff[8+i]) mSir[i] = (mSir[i] < DEB) ? mSir[i] + 1 : DEB;
        else mSir[i] = 0;
      end
      mPendA = mEff[3:0] & ~mPrevA;
      mPendD = mEff[7:4] & ~mPrevD;
      mPrevA = mEff[3:0];
      mPrevD = mEff[7:4];
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] d);
    veh_arr = a;
    veh_dep = d;
    @(negedge clk);
    veh_arr = '0;
    veh_dep = '0;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (4 + SYNC_LAT) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    veh_arr = '0; veh_dep = '0; siren = '0;
    repeat (3) @(negedge clk);
    testsRun++;
    if ({emergency, jam, empty, sensor_err} !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got em=%b jam=%b empty=%b err=%b want all 0", emergency, jam, empty, sensor_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_empty_idle();
    logic [3:0] wantEmpty;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      wantEmpty = (cyc >= HOLD) ? 4'b1111 : 4'b0000;
      testsRun++;
      if (empty !== wantEmpty || jam !== 4'b0 || emergency !== 4'b0) begin
        testsFailed++;
        $display("[TB] FAIL empty_idle cyc %0d: got empty=%b jam=%b em=%b want empty=%b jam=0 em=0", cyc, empty, jam, emergency, wantEmpty);
      end
    end
  endtask

  task automatic test_jam();
    repeat (12) applyStimulus(4'b0100, 4'b0000);
    settle();
    testsRun++;
    if (jam !== 4'b0100 || empty[2] !== 1'b0 || {jam, empty} !== {mJam, mEmpty}) begin
      testsFailed++;
      $display("[TB] FAIL jam_set: got jam=%b empty=%b want jam=0100 empty=%b", jam, empty, mEmpty);
    end
    repeat (4) applyStimulus(4'b0000, 4'b0100);
    settle();
    testsRun++;
    if (jam[2] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL jam_hyst_hold occ8: got jam=%b want jam[2]=1", jam);
    end
    applyStimulus(4'b0000, 4'b0100);
    settle();
    testsRun++;
    if (jam[2] !== 1'b0 || empty[2] !== 1'b0 || sensor_err !== mErr) begin
      testsFailed++;
      $display("[TB] FAIL jam_clear occ7: got jam=%b empty=%b err=%b want jam[2]=0 empty[2]=0 err=%b", jam, empty, sensor_err, mErr);
    end
  endtask

  task automatic test_siren();
    siren = 4'b0010;
    repeat (2) @(negedge clk);
    siren = 4'b0000;
    repeat (6) @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL siren_short: got em=%b want 0000", emergency);
    end
    siren = 4'b0010;
    repeat (DEB + SYNC_LAT) @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL siren_early: got em=%b want 0000", emergency);
    end
    @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL siren_valid_s: got em=%b want 0010", emergency);
    end
    siren = 4'b0011;
    repeat (DEB + SYNC_LAT) @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL siren_n_pending: got em=%b want 0010", emergency);
    end
    @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL siren_priority_n: got em=%b want 0001", emergency);
    end
    siren = 4'b0010;
    repeat (1 + SYNC_LAT) @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL siren_drop_lag: got em=%b want 0001", emergency);
    end
    @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0010) begin
      testsFailed++;
      $display("[TB] FAIL siren_takeover_s: got em=%b want 0010", emergency);
    end
    siren = 4'b0000;
    repeat (2 + SYNC_LAT) @(negedge clk);
    testsRun++;
    if (emergency !== 4'b0000 || emergency !== mEm) begin
      testsFailed++;
      $display("[TB] FAIL siren_release: got em=%b want 0000", emergency);
    end
  endtask

  task automatic test_back_to_back();
    repeat (5) applyStimulus(4'b1000, 4'b0000);
    settle();
    applyStimulus(4'b1000, 4'b1000);
    settle();
    testsRun++;
    if (sensor_err[3] !== 1'b0 || jam[3] !== 1'b0 || empty[3] !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL simultaneous_w: got err=%b jam=%b empty=%b want err[3]=0 jam[3]=0 empty[3]=0", sensor_err, jam, empty);
    end
    repeat (5) applyStimulus(4'b0000, 4'b1000);
    repeat (HOLD + 4 + SYNC_LAT) @(negedge clk);
    testsRun++;
    if (sensor_err[3] !== 1'b0 || empty[3] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL drain_w: got err=%b empty=%b want err[3]=0 empty[3]=1", sensor_err, empty);
    end
    applyStimulus(4'b0000, 4'b0001);
    settle();
    testsRun++;
    if (sensor_err !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL underflow_n: got err=%b want 0001", sensor_err);
    end
    repeat (10) @(negedge clk);
    testsRun++;
    if (sensor_err !== 4'b0001 || sensor_err !== mErr) begin
      testsFailed++;
      $display("[TB] FAIL err_sticky: got err=%b want 0001", sensor_err);
    end
  endtask

  task automatic test_saturation_reset();
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(4'b0010, 4'b0000);
      if (n == 15) begin
        settle();
        testsRun++;
        if (jam[1] !== 1'b1 || sensor_err[1] !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL fill_s_15: got jam=%b err=%b want jam[1]=1 err[1]=0", jam, sensor_err);
        end
      end
    end
    settle();
    testsRun++;
    if (sensor_err !== 4'b0011 || jam[1] !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL overflow_s: got err=%b jam=%b want err=0011 jam[1]=1", sensor_err, jam);
    end
    siren = 4'b0100;
    applyStimulus(4'b0010, 4'b0000);
    veh_arr = 4'b0010;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    testsRun++;
    if ({emergency, jam, empty, sensor_err} !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got em=%b jam=%b empty=%b err=%b want all 0", emergency, jam, empty, sensor_err);
    end
    veh_arr = '0;
    siren = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (HOLD - 1) @(negedge clk);
    testsRun++;
    if ({emergency, jam, empty, sensor_err} !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_clean: got em=%b jam=%b empty=%b err=%b want all 0", emergency, jam, empty, sensor_err);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 200) begin
        veh_arr = 4'($urandom_range(0, 15));
        veh_dep = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      end else begin
        veh_arr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        veh_dep = 4'($urandom_range(0, 15));
      end
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) siren[i] = ~siren[i];
      @(negedge clk);
      testsRun++;
      if ({emergency, jam, empty, sensor_err} !== {mEm, mJam, mEmpty, mErr}) begin
        testsFailed++;
        $display("[TB] FAIL random cyc %0d: got em=%b jam=%b empty=%b err=%b want em=%b jam=%b empty=%b err=%b",
                 cyc, emergency, jam, empty, sensor_err, mEm, mJam, mEmpty, mErr);
      end
    end
    veh_arr = '0; veh_dep = '0; siren = '0;
  endtask

  initial begin
    test_reset();
    test_empty_idle();
    test_jam();
    test_siren();
    test_back_to_back();
    test_saturation_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
